// File: rtl/rc4_stream_xor.sv
// ---------------------------------------------------------------------------
// rc4_stream_xor
//   Consumer side of an rc4 keystream interface. Keystream bytes from the
//   generator are buffered in a small FIFO and XORed with a message byte
//   stream, one byte per clock at full rate. Encrypt and decrypt are the same
//   operation. The first DROP_N keystream bytes of each message can be
//   discarded (RC4-drop[n]). All three byte streams use valid/ready.
//
//   Parameters
//     DROP_N      keystream bytes discarded after each start (0..255)
//     FIFO_DEPTH  keystream buffer depth, power of 2, >= 2
//     LEN_W       width of the message length and byte counter
//
//   Ports
//     clk, rst                 clock (rising edge), async active-high reset
//     start, msg_len           start pulse in IDLE, message length in bytes
//     busy, done, byte_cnt     message status
//     ks_valid/ks_byte/ks_ready      keystream input stream
//     din_valid/din/din_ready        message input stream
//     dout_valid/dout/dout_ready     result output stream
//
//   A second module, rc4_ks_fifo, holds the keystream buffer.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// rc4_ks_fifo
//   Byte FIFO with a combinational head. Push and pop in the same cycle are
//   both honoured and leave the count unchanged. Pointers wrap naturally
//   because DEPTH is a power of two.
//
//   Ports
//     clk, rst          clock, async active-high reset
//     push, wr_data     write strobe and byte (caller never pushes when full)
//     pop               read strobe (caller never pops when empty)
//     head              oldest stored byte
//     count             number of stored bytes (0..DEPTH)
//     full, nonempty    status flags derived from count
// ---------------------------------------------------------------------------
module rc4_ks_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       wr_data,
  input  logic             pop,
  output logic [7:0]       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             nonempty
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [DEPTH-1:0][7:0] entry_q;

  // One register per slot; only the slot addressed by the write pointer
  // loads on a push.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [7:0] data_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= 8'h00;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          data_reg <= wr_data;
        end
      end

      assign entry_q[gi] = data_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      // Simultaneous push and pop cancel out in the count.
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  assign head     = entry_q[rd_ptr_reg];
  assign count    = count_reg;
  assign full     = (count_reg == FULL_CNT);
  assign nonempty = (count_reg != '0);

endmodule

module rc4_stream_xor #(
  parameter int DROP_N     = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] byte_cnt,
  input  logic             ks_valid,
  input  logic [7:0]       ks_byte,
  output logic             ks_ready,
  input  logic             din_valid,
  input  logic [7:0]       din,
  output logic             din_ready,
  output logic             dout_valid,
  output logic [7:0]       dout,
  input  logic             dout_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EXT_W = LEN_W + 1;
  // Value of drop_cnt_reg when the final discarded byte is accepted.
  localparam logic [7:0] DROP_LAST = (DROP_N > 0) ? 8'(DROP_N - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DROP = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t           state_reg;
  logic [LEN_W-1:0] rem_reg;        // message bytes not yet taken from din
  logic [LEN_W-1:0] byte_cnt_reg;   // dout bytes accepted downstream
  logic [7:0]       drop_cnt_reg;   // keystream bytes discarded so far
  logic             busy_reg;
  logic             done_zero_reg;  // done pulse for a zero-length message
  logic [7:0]       dout_reg;
  logic             dout_valid_reg;

  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_nonempty;
  logic [EXT_W-1:0] fifo_count_ext;

  logic ks_room;
  logic out_free;
  logic ks_hs;
  logic fifo_push;
  logic drop_hs;
  logic din_hs;
  logic dout_hs;
  logic last_out;

  // -------------------------------------------------------------------------
  // Stream control
  // -------------------------------------------------------------------------
  assign fifo_count_ext = EXT_W'(fifo_count);

  // Only fetch keystream that this message will still consume. Because
  // count <= rem always holds, the FIFO drains to empty exactly when the
  // message ends and the next message starts keystream-aligned.
  assign ks_room = ({1'b0, rem_reg} > fifo_count_ext);

  // The output register can take a new byte if it is empty or being drained.
  assign out_free = !dout_valid_reg || dout_ready;

  always_comb begin
    ks_ready = 1'b0;
    case (state_reg)
      ST_DROP: ks_ready = 1'b1;
      ST_XFER: ks_ready = !fifo_full && ks_room;
      default: ks_ready = 1'b0;
    endcase
  end

  assign din_ready = (state_reg == ST_XFER) && fifo_nonempty &&
                     (rem_reg != '0) && out_free;

  assign ks_hs     = ks_valid && ks_ready;
  assign fifo_push = ks_hs && (state_reg == ST_XFER);
  assign drop_hs   = ks_hs && (state_reg == ST_DROP);
  assign din_hs    = din_valid && din_ready;
  assign dout_hs   = dout_valid_reg && dout_ready;

  // With rem at zero the output register holds the final byte of the
  // message, so its handshake ends the transfer.
  assign last_out  = (state_reg == ST_XFER) && (rem_reg == '0) && dout_hs;

  // -------------------------------------------------------------------------
  // Keystream buffer
  // -------------------------------------------------------------------------
  rc4_ks_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ks_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .wr_data  (ks_byte),
    .pop      (din_hs),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .nonempty (fifo_nonempty)
  );

  // -------------------------------------------------------------------------
  // Control FSM, counters and output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      rem_reg        <= '0;
      byte_cnt_reg   <= '0;
      drop_cnt_reg   <= 8'd0;
      busy_reg       <= 1'b0;
      done_zero_reg  <= 1'b0;
      dout_reg       <= 8'h00;
      dout_valid_reg <= 1'b0;
    end else begin
      done_zero_reg <= 1'b0;

      // Output register: load on a din handshake, otherwise hold until the
      // consumer takes the byte.
      if (din_hs) begin
        dout_reg       <= din ^ fifo_head;
        dout_valid_reg <= 1'b1;
      end else if (dout_ready) begin
        dout_valid_reg <= 1'b0;
      end

      if (dout_hs) begin
        byte_cnt_reg <= byte_cnt_reg + LEN_W'(1);
      end

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            rem_reg      <= msg_len;
            byte_cnt_reg <= '0;
            drop_cnt_reg <= 8'd0;
            if (msg_len == '0) begin
              done_zero_reg <= 1'b1;
            end else begin
              busy_reg  <= 1'b1;
              state_reg <= (DROP_N > 0) ? ST_DROP : ST_XFER;
            end
          end
        end

        ST_DROP: begin
          if (drop_hs) begin
            if (drop_cnt_reg == DROP_LAST) begin
              drop_cnt_reg <= 8'd0;
              state_reg    <= ST_XFER;
            end else begin
              drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
          end
        end

        ST_XFER: begin
          if (din_hs) begin
            rem_reg <= rem_reg - LEN_W'(1);
          end
          if (last_out) begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_zero_reg || last_out;
  assign byte_cnt   = byte_cnt_reg;
  assign dout_valid = dout_valid_reg;
  assign dout       = dout_reg;

endmodule
